// File: rtl/dpll_pkg.sv
// Shared definitions for the receive DPLL: period width, default timing and
// phase classification helpers used by the bit synchronizer and period correction.
package dpll_pkg;

  localparam int PER_W      = 4;
  localparam int N          = 8;
  localparam int MIN_PERIOD = 4;

  typedef enum logic [1:0] {
    PH_ALIGNED,
    PH_AHEAD,
    PH_BEHIND
  } phase_e;

  // A period below the floor would squeeze two strobes too close together.
  function automatic logic [PER_W-1:0] clamp_period(input logic [PER_W-1:0] p,
                                                    input logic [PER_W-1:0] lo);
    return (p < lo) ? lo : p;
  endfunction

  // Edge position relative to the local bit boundary at cnt == 0.
  function automatic phase_e classify(input logic [PER_W-1:0] cnt,
                                      input logic [PER_W-1:0] half);
    if (cnt == '0)
      return PH_ALIGNED;
    else if (cnt < half)
      return PH_AHEAD;
    else
      return PH_BEHIND;
  endfunction

endpackage

// File: rtl/bit_sync_tracker_if.sv
// Serial line, period feedback and recovered-bit signals between the bit
// synchronizer (slave) and its environment (master).
interface bit_sync_tracker_if;
  import dpll_pkg::*;

  logic             din;
  logic [PER_W-1:0] num;
  logic             ahead;
  logic             behind;
  logic             bit_out;
  logic             bit_vld;

  modport master (
    output din,
    output num,
    input  ahead,
    input  behind,
    input  bit_out,
    input  bit_vld
  );

  modport slave (
    input  din,
    input  num,
    output ahead,
    output behind,
    output bit_out,
    output bit_vld
  );

endinterface

// File: rtl/din_edge_det.sv
// Two-flop synchronizer and registered edge detector for the serial input.
// BIT_SYNC_GLITCH_FILTER_EN inserts a 3-tap majority filter after the synchronizer.
module din_edge_det #(
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic data_edge,
  output logic level
);

  logic sync1;
  logic sync2;
  logic sync3;
  logic edge_q;
  logic stage;

  // NOTE: every flop in the chain updates with <= so each stage sees the
  // previous stage's old value; blocking assignments would collapse the chain.
  // NOTE: synchronizer flops reset to the line idle level, not zero, so
  // releasing reset on an idle line does not manufacture an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= IDLE_LVL;
      sync2 <= IDLE_LVL;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

`ifdef BIT_SYNC_GLITCH_FILTER_EN
  logic tap0;
  logic tap1;
  logic filt;

  // A level must be present in two of three consecutive samples to pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap0 <= IDLE_LVL;
      tap1 <= IDLE_LVL;
      filt <= IDLE_LVL;
    end else begin
      tap0 <= sync2;
      tap1 <= tap0;
      filt <= (sync2 & tap0) | (sync2 & tap1) | (tap0 & tap1);
    end
  end

  assign stage = filt;
`else
  assign stage = sync2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync3  <= IDLE_LVL;
      edge_q <= 1'b0;
    end else begin
      sync3  <= stage;
      edge_q <= stage ^ sync3;
    end
  end

  assign data_edge = edge_q;
  assign level     = sync3;

endmodule

// File: rtl/bit_sync_tracker.sv
// Receive DPLL bit synchronizer: period counter, early/late edge classifier and
// mid-bit sampler. BIT_SYNC_GLITCH_FILTER_EN enables the input majority filter.
module bit_sync_tracker #(
  parameter int   N          = dpll_pkg::N,
  parameter int   MIN_PERIOD = dpll_pkg::MIN_PERIOD,
  parameter logic IDLE_LVL   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  bit_sync_tracker_if.slave  bus
);

  localparam int W = dpll_pkg::PER_W;
  localparam logic [W-1:0] RST_PER = W'(N);
  localparam logic [W-1:0] MIN_PER = W'(MIN_PERIOD);

  logic [W-1:0]     cnt;
  logic [W-1:0]     per_q;
  logic [W-1:0]     half;
  logic             term;
  logic             data_edge;
  logic             level;
  logic             ahead_q;
  logic             behind_q;
  logic             bit_q;
  logic             vld_q;
  dpll_pkg::phase_e phase;

  din_edge_det #(
    .IDLE_LVL (IDLE_LVL)
  ) u_edge (
    .clk       (clk),
    .rst       (rst),
    .din       (bus.din),
    .data_edge (data_edge),
    .level     (level)
  );

  assign half = per_q >> 1;
  assign term = (cnt == per_q - 1'b1);

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned and infers a latch.
  always_comb begin
    phase = dpll_pkg::PH_ALIGNED;
    if (data_edge)
      phase = dpll_pkg::classify(cnt, half);
  end

  // num is only consulted at the boundary; the correction block may change it freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      per_q <= RST_PER;
    end else if (term) begin
      cnt   <= '0;
      per_q <= dpll_pkg::clamp_period(bus.num, MIN_PER);
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A terminal-cycle edge always classifies as behind and wins over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ahead_q  <= 1'b0;
      behind_q <= 1'b0;
    end else if (data_edge) begin
      ahead_q  <= (phase == dpll_pkg::PH_AHEAD);
      behind_q <= (phase == dpll_pkg::PH_BEHIND);
    end else if (term) begin
      ahead_q  <= 1'b0;
      behind_q <= 1'b0;
    end
  end

  // Sample mid-bit, as far as possible from the expected data transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_q <= IDLE_LVL;
      vld_q <= 1'b0;
    end else begin
      vld_q <= (cnt == half);
      if (cnt == half)
        bit_q <= level;
    end
  end

  assign bus.ahead   = ahead_q;
  assign bus.behind  = behind_q;
  assign bus.bit_out = bit_q;
  assign bus.bit_vld = vld_q;

endmodule

// File: tb/tb_bit_sync_tracker.sv
// Directed bench for bit_sync_tracker: expected strobes go into a scoreboard
// queue checked by a monitor; flags and period are checked against hand-timed values.
module tb_bit_sync_tracker;
  import dpll_pkg::*;

`ifdef BIT_SYNC_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  typedef enum {M_FIXED8, M_MODEL, M_CLAMP} mode_e;
  typedef struct {
    int   cyc;
    logic b;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  mode_e mode = M_FIXED8;
  logic  sb_en = 1'b0;
  int    cyc;
  int    n_checks = 0;
  int    n_errors = 0;
  exp_t  sb_q[$];

  always #5 clk = ~clk;

  bit_sync_tracker_if bus ();

  bit_sync_tracker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Cycle index: number of rising edges since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Stand-in for the period-correction block.
  always_comb begin
    bus.num = 4'd8;
    case (mode)
      M_MODEL: bus.num = bus.ahead ? 4'd9 : (bus.behind ? 4'd7 : 4'd8);
      M_CLAMP: bus.num = 4'd2;
      default: bus.num = 4'd8;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic b);
    exp_t e;
    e.cyc = c;
    e.b   = b;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string name);
    check(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic restart();
    sb_en   = 1'b0;
    rst     = 1'b0;
    bus.din = 1'b1;
    repeat (3) @(negedge clk);
    sb_q.delete();
    rst   = 1'b1;
    sb_en = 1'b1;
  endtask

  // Scoreboard monitor: every strobe must match the next expected one.
  always @(negedge clk) begin
    if (sb_en && rst && bus.bit_vld) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: cycle %0d bit %0d with nothing expected", cyc, bus.bit_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_bit", int'(bus.bit_out), int'(e.b));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.din = 1'b1;

    // Reset held with the line toggling.
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      bus.din = ~bus.din;
    end
    check("rst_ahead", int'(bus.ahead), 0);
    check("rst_behind", int'(bus.behind), 0);
    check("rst_bit_out", int'(bus.bit_out), 1);
    check("rst_bit_vld", int'(bus.bit_vld), 0);
    check("rst_per_q", int'(dut.per_q), 8);
    check("rst_cnt", int'(dut.cnt), 0);
    @(negedge clk);
    bus.din = 1'b1;
    @(negedge clk);
    rst   = 1'b1;
    sb_en = 1'b1;

    // Lock: edges land on cnt == 0, bits 1,0,1,1,0, first strobe 5 clocks in.
    mode = M_FIXED8;
    push(5, 1'b1); push(13, 1'b0); push(21, 1'b1); push(29, 1'b1); push(37, 1'b0);
    while (cyc < 40) begin
      @(negedge clk);
      check("lock_flags", int'({bus.ahead, bus.behind}), 0);
      if (cyc == 8 - LAT)  bus.din = 1'b0;
      if (cyc == 16 - LAT) bus.din = 1'b1;
      if (cyc == 32 - LAT) bus.din = 1'b0;
    end
    drain("lock_drain");

    // Early local clock: edge at cnt 2, next period 9.
    restart();
    mode = M_MODEL;
    push(5, 1'b1); push(13, 1'b0); push(21, 1'b0); push(30, 1'b0);
    while (cyc < 32) begin
      @(negedge clk);
      check("early_behind", int'(bus.behind), 0);
      if (cyc == 10) check("early_ahead_pre", int'(bus.ahead), 0);
      if (cyc >= 11 && cyc <= 15) check("early_ahead_held", int'(bus.ahead), 1);
      if (cyc == 16) check("early_ahead_clr", int'(bus.ahead), 0);
      if (cyc == 15) check("early_per_old", int'(dut.per_q), 8);
      if (cyc == 16) check("early_per_new", int'(dut.per_q), 9);
      if (cyc == 24) check("early_per_hold", int'(dut.per_q), 9);
      if (cyc == 25) check("early_per_back", int'(dut.per_q), 8);
      if (cyc == 10 - LAT) bus.din = 1'b0;
    end
    drain("early_drain");

    // Late local clock: edge at cnt 6, then an edge on the terminal cycle.
    restart();
    mode = M_MODEL;
    push(5, 1'b1); push(13, 1'b1); push(20, 1'b0); push(28, 1'b1); push(35, 1'b1);
    while (cyc < 37) begin
      @(negedge clk);
      check("late_ahead", int'(bus.ahead), 0);
      if (cyc == 14) check("late_behind_pre", int'(bus.behind), 0);
      if (cyc == 15) check("late_behind_set", int'(bus.behind), 1);
      if (cyc == 16) check("late_behind_clr", int'(bus.behind), 0);
      if (cyc == 22) check("late_behind_term_pre", int'(bus.behind), 0);
      if (cyc >= 23 && cyc <= 30) check("late_behind_term", int'(bus.behind), 1);
      if (cyc == 31) check("late_behind_clr2", int'(bus.behind), 0);
      if (cyc == 16) check("late_per_7", int'(dut.per_q), 7);
      if (cyc == 23) check("late_per_8", int'(dut.per_q), 8);
      if (cyc == 31) check("late_per_7b", int'(dut.per_q), 7);
      if (cyc == 14 - LAT) bus.din = 1'b0;
      if (cyc == 22 - LAT) bus.din = 1'b1;
    end
    drain("late_drain");

    // Clamp num=2 up to 4, then return to 8 and reset mid-period at cnt 5.
    restart();
    mode = M_CLAMP;
    push(5, 1'b1); push(11, 1'b1); push(15, 1'b1); push(19, 1'b1); push(25, 1'b0);
    while (cyc < 25) begin
      @(negedge clk);
      if (cyc == 7)  check("clamp_per_init", int'(dut.per_q), 8);
      if (cyc == 8)  check("clamp_per_min", int'(dut.per_q), 4);
      if (cyc == 12) check("clamp_per_hold", int'(dut.per_q), 4);
      if (cyc == 20) check("clamp_per_8", int'(dut.per_q), 8);
      if (cyc == 24) check("clamp_ahead", int'(bus.ahead), 1);
      if (cyc == 17) mode = M_FIXED8;
      if (cyc == 23 - LAT) bus.din = 1'b0;
    end
    check("mid_pre_cnt", int'(dut.cnt), 5);
    check("mid_pre_vld", int'(bus.bit_vld), 1);
    #2 rst = 1'b0;
    #1;
    check("mid_cnt", int'(dut.cnt), 0);
    check("mid_per_q", int'(dut.per_q), 8);
    check("mid_ahead", int'(bus.ahead), 0);
    check("mid_behind", int'(bus.behind), 0);
    check("mid_bit_vld", int'(bus.bit_vld), 0);
    check("mid_bit_out", int'(bus.bit_out), 1);
    drain("clamp_drain");

`ifdef BIT_SYNC_GLITCH_FILTER_EN
    // One-cycle pulse is rejected; a three-cycle pulse yields an edge 5 clocks later.
    restart();
    sb_en = 1'b0;
    mode  = M_FIXED8;
    while (cyc < 30) begin
      @(negedge clk);
      if (cyc >= 1 && cyc <= 15) begin
        check("glitch_edge", int'(dut.data_edge), 0);
        check("glitch_flags", int'({bus.ahead, bus.behind}), 0);
      end
      if (cyc == 24) check("pulse_edge_pre", int'(dut.data_edge), 0);
      if (cyc == 25) check("pulse_edge", int'(dut.data_edge), 1);
      if (cyc == 2)  bus.din = 1'b0;
      if (cyc == 3)  bus.din = 1'b1;
      if (cyc == 20) bus.din = 1'b0;
      if (cyc == 23) bus.din = 1'b1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bit_sync_tracker.md
# bit_sync_tracker

Bit-synchronizer front end of the receive DPLL. Oversamples the serial input `din`, runs a loadable period counter that defines bit boundaries, and classifies each data edge as early or late relative to the local boundary. Drives `ahead`/`behind` to the period-correction block and accepts its combinational `num` period value back, closing the loop. Emits one sampled bit per period to the downstream deframer.

## Interface
- `N`, 8: reset and default bit period in `clk` cycles.
- `MIN_PERIOD`, 4: smallest period honoured; smaller `num` values are clamped up to it.
- `IDLE_LVL`, 1'b1: line idle level; reset value of the synchronizer flops.

- `clk`  in  1  sole clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `din`  in  1  asynchronous serial data.
- `num`  in  4  next bit period from the correction block.
- `ahead`  out  1  local boundary preceded the data edge; lengthen next period.
- `behind`  out  1  data edge preceded the local boundary; shorten next period.
- `bit_out`  out  1  sampled data bit.
- `bit_vld`  out  1  one-cycle strobe; `bit_out` is valid in the same cycle.

## Operation
- Synchronizer: two flops on `din`, then an edge register. `edge` = sync2 XOR sync3.
- Period counter `cnt` (4 bits) runs 0..`per_q`-1. Terminal count is `cnt == per_q-1`; on terminal, `cnt` goes to 0 and `per_q` loads max(`num`, MIN_PERIOD).
- Phase classification in any cycle with `edge`=1, using `half = per_q >> 1`:
  - `cnt == 0`: aligned. Both flags clear.
  - `1 <= cnt < half`: `ahead` set, `behind` clear.
  - `cnt >= half`: `behind` set, `ahead` clear.
- Flags are held until the next terminal cycle. On the terminal cycle they clear unless that same cycle carries an edge. A terminal-cycle edge has `cnt >= half`, so `behind` is set, and this takes priority over the clear.
- Sampling: at `cnt == half`, `bit_out` loads sync3 and `bit_vld` pulses for one cycle.
- Multiple edges in one period: the last edge wins.
- `num` is read only on the terminal cycle. Changes at other times have no effect.

## Timing
- Reset values: `cnt`=0, `per_q`=N, `ahead`=0, `behind`=0, `bit_out`=IDLE_LVL, `bit_vld`=0, synchronizer flops=IDLE_LVL.
- Reset assertion clears all state immediately, including mid-period. After release, the first `bit_vld` occurs at `cnt == N>>1`, i.e. N/2 + 1 clocks after the first active edge.
- `din` to `edge`: 3 clocks. A `din` change set up before clock k gives `edge`=1 in the cycle after edge k+2.
- `edge` to flag: 1 clock; the flag is registered.
- Flag to period change: `ahead`/`behind` drive `num` combinationally, and the new value is taken at the next terminal cycle. The correction applies to the period that starts after that terminal cycle.
- `bit_vld` rate: exactly one strobe per period, never two closer than MIN_PERIOD cycles.

## Configuration
- `BIT_SYNC_GLITCH_FILTER_EN`
- Defined: a 3-tap majority filter sits between sync2 and the edge register. Single-cycle pulses on `din` are rejected. `din`-to-`edge` latency becomes 5 clocks, and `bit_out` samples the filtered level.
- Undefined: no filter; 3-clock latency as stated above.

## Structure
- Shared package `dpll_pkg`:
  - `PER_W` = 4
  - default period `N` = 8
  - `MIN_PERIOD` = 4
  - enum `phase_e` {`PH_ALIGNED`, `PH_AHEAD`, `PH_BEHIND`}
- The period-correction block uses the same package.
- One sub-module, `din_edge_det`: synchronizer, optional majority filter, and edge output.
- The counter, classifier and sampler live in the top module.

## Test plan
- Reset: hold `rst`=0 with `din` toggling; all outputs at reset values and `per_q`=8. Release; first `bit_vld` at `cnt`=4.
- Lock, with `num` tied to 8: `din` edges timed so that `edge` hits `cnt`=0. `ahead`=`behind`=0 throughout; `bit_vld` every 8 clocks; `bit_out` reproduces 1,0,1,1,0.
- Early local clock, with the bench model `num`=9 when `ahead`=1: `edge` at `cnt`=2. `ahead`=1 until the terminal cycle, the next period is 9 clocks, and the flag then clears.
- Late local clock: `edge` at `cnt`=6 with `per_q`=8. `behind`=1 and the next period is 7 with the model `num`=7. `edge` on the terminal cycle (`cnt`=7) leaves `behind`=1 for the following period.
- Clamp and mid-operation reset: `num`=2 gives a period of 4. Then `rst`=0 at `cnt`=5: everything clears in the same cycle and `per_q` returns to 8.
- With `BIT_SYNC_GLITCH_FILTER_EN`: a 1-cycle `din` pulse produces no edge and no flag. A 3-cycle pulse produces `edge` 5 clocks after onset.
